alu_seq: RTL and testbench

Multi-word sequencer that sits directly upstream of the combinational 16-bit `alu`: it accepts 16- to 64-bit operations over a valid/ready command port and drives `alu` one 16-bit word per cycle, LSB first, chaining carry between words. It collects the per-word `Result`/`Status`, combines them into one 64-bit result and a 6-bit status, and presents them on a valid/ready output port. It also holds the architectural flags register that downstream logic reads.

---
 rtl/alu_seq.sv | 144 ++++++++++++++
 tb/tb_alu_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-word sequencer in front of the 16-bit combinational alu: one word per cycle, LSB first,
// with carry chained between words, result/status combining and the architectural flags register.
module alu_seq #(
    parameter int MAX_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [16*MAX_WORDS-1:0]   in_a,
    input  logic [16*MAX_WORDS-1:0]   in_b,
    input  logic [4:0]                in_f,
    input  logic                      in_cin,
    input  logic                      in_cin_sel,
    input  logic [1:0]                in_len,
    output logic [15:0]               alu_a,
    output logic [15:0]               alu_b,
    output logic [4:0]                alu_f,
    output logic                      alu_cin,
    input  logic [15:0]               alu_result,
    input  logic [5:0]                alu_status,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [16*MAX_WORDS-1:0]   out_result,
    output logic [5:0]                out_status,
    output logic [5:0]                flags
);

    localparam int DW = 16 * MAX_WORDS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_r;
    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    logic [4:0]    f_r;
    logic [1:0]    len_r;
    logic [1:0]    idx_r;
    logic          cin0_r;
    logic          carry_r;
    logic          zacc_r;
    logic [DW-1:0] out_result_r;
    logic [5:0]    out_status_r;
    logic [5:0]    flags_r;

    logic          exec_s;
    logic [5:0]    word_lsb_s;
    logic [15:0]   word_a_s;
    logic [15:0]   word_b_s;
    logic          last_word_s;

    assign exec_s      = (state_r == S_EXEC);
    assign word_lsb_s  = {idx_r, 4'b0000};
    assign last_word_s = (idx_r == len_r);

    // Select the latched operand words addressed by idx.
    always_comb begin
        word_a_s = a_r[word_lsb_s +: 16];
        word_b_s = b_r[word_lsb_s +: 16];
    end

    // Drive the alu only while executing; word 0 takes cin0, later words take the chained carry.
    always_comb begin
        alu_a   = 16'd0;
        alu_b   = 16'd0;
        alu_f   = 5'd0;
        alu_cin = 1'b0;
        if (exec_s) begin
            alu_a   = word_a_s;
            alu_b   = word_b_s;
            alu_f   = f_r;
            alu_cin = (idx_r == 2'd0) ? cin0_r : carry_r;
        end else begin
            alu_a   = 16'd0;
            alu_b   = 16'd0;
            alu_f   = 5'd0;
            alu_cin = 1'b0;
        end
    end

    // Sequencer state, per-word capture, status combining and flags update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            a_r          <= '0;
            b_r          <= '0;
            f_r          <= 5'd0;
            len_r        <= 2'd0;
            idx_r        <= 2'd0;
            cin0_r       <= 1'b0;
            carry_r      <= 1'b0;
            zacc_r       <= 1'b0;
            out_result_r <= '0;
            out_status_r <= 6'd0;
            flags_r      <= 6'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r          <= in_a;
                        b_r          <= in_b;
                        f_r          <= in_f;
                        len_r        <= in_len;
                        cin0_r       <= in_cin_sel ? flags_r[5] : in_cin;
                        idx_r        <= 2'd0;
                        out_result_r <= '0;
                        zacc_r       <= 1'b1;
                        state_r      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    out_result_r[word_lsb_s +: 16] <= alu_result;
                    carry_r <= alu_status[5];
                    zacc_r  <= zacc_r & alu_status[4];
                    // Whole-result ZF needs every word zero, not just the last one.
                    if (last_word_s) begin
                        out_status_r <= {alu_status[5], zacc_r & alu_status[4], alu_status[3:0]};
                        state_r      <= S_DONE;
                    end else begin
                        idx_r <= idx_r + 2'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        flags_r <= out_status_r;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_r == S_IDLE);
    assign out_valid  = (state_r == S_DONE);
    assign out_result = out_result_r;
    assign out_status = out_status_r;
    assign flags      = flags_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a stand-in 16-bit alu and a word-loop reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, in_cin, in_cin_sel;
    logic [63:0] in_a, in_b;
    logic [4:0]  in_f;
    logic [1:0]  in_len;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_f;
    logic        alu_cin;
    logic [5:0]  alu_status;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic [5:0]  out_status, flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 1;     // 0 random, 1 always ready, 2 stalled
    logic [5:0] model_flags = 6'd0;

    typedef struct {
        logic [63:0] res;
        logic [5:0]  st;
        int          acc_cyc;
        int          len;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq #(.MAX_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_f(in_f),
        .in_cin(in_cin), .in_cin_sel(in_cin_sel), .in_len(in_len),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_status(alu_status),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_status(out_status), .flags(flags)
    );

    // Stand-in alu: returns {result, CF, ZF, NF, VF, PF, AF}.
    function automatic logic [21:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [4:0] f, input logic c);
        logic [16:0] t;
        logic [4:0]  h;
        logic [15:0] r;
        logic        cf, vf, af;
        t = 17'd0; h = 5'd0; r = 16'd0; cf = 1'b0; vf = 1'b0; af = 1'b0;
        case (f)
            5'd0: begin
                t = {1'b0, a} + {1'b0, b} + {16'd0, c};
                h = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, c};
                r = t[15:0]; cf = t[16]; af = h[4];
                vf = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'd1: begin
                t = {1'b0, a} - {1'b0, b} - {16'd0, c};
                h = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, c};
                r = t[15:0]; cf = t[16]; af = h[4];
                vf = (a[15] != b[15]) && (r[15] != a[15]);
            end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            5'd5: r = ~a;
            default: begin r = a; cf = c; end
        endcase
        return {r, cf, (r == 16'd0), r[15], vf, ~^r[7:0], af};
    endfunction

    always_comb {alu_result, alu_status} = alu_fn(alu_a, alu_b, alu_f, alu_cin);

    // Reference: run the operation word by word, then judge ZF over the whole masked result.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [4:0] f, input logic cin0, input logic [1:0] len);
        exp_t e;
        logic c;
        logic [21:0] w;
        logic [5:0] last;
        c = cin0; last = 6'd0;
        e.res = 64'd0;
        for (int k = 0; k <= int'(len); k++) begin
            w = alu_fn(a[16*k +: 16], b[16*k +: 16], f, c);
            e.res[16*k +: 16] = w[21:6];
            last = w[5:0];
            c = w[5];
        end
        e.st = {last[5], (e.res == 64'd0), last[3:0]};
        e.acc_cyc = 0;
        e.len = int'(len);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [4:0] f,
                        input logic cin, input logic sel, input logic [1:0] len);
        int waitc;
        exp_t e;
        waitc = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_f = f; in_cin = cin; in_cin_sel = sel; in_len = len;
        in_valid = 1'b1;
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        e = model(a, b, f, sel ? model_flags[5] : cin, len);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL valid_timeout: out_valid stayed %b, expected 1", out_valid);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // Monitor: drives out_ready, pops expected results on each handshake and checks flags after.
    initial begin : monitor
        bit seen, pend;
        logic [5:0] pend_flags;
        exp_t e;
        seen = 1'b0; pend = 1'b0; pend_flags = 6'd0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0; pend = 1'b0; out_ready = 1'b0;
                model_flags = 6'd0;
                exp_q.delete();
            end else begin
                if (pend) begin
                    chk("flags_after_handshake", {58'd0, flags}, {58'd0, pend_flags});
                    pend = 1'b0;
                end
                if (ready_mode == 2)      out_ready = 1'b0;
                else if (ready_mode == 1) out_ready = 1'b1;
                else                      out_ready = ($urandom_range(0, 3) != 0);
                if (out_valid && exp_q.size() == 0 && out_ready) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: out_valid=1 with no outstanding command");
                end else if (out_valid && exp_q.size() != 0) begin
                    if (!seen) begin
                        chk("valid_latency", 64'(cyc), 64'(exp_q[0].acc_cyc + exp_q[0].len + 2));
                        seen = 1'b1;
                    end
                    if (out_ready) begin
                        e = exp_q.pop_front();
                        chk("out_result", out_result, e.res);
                        chk("out_status", {58'd0, out_status}, {58'd0, e.st});
                        model_flags = e.st;
                        pend_flags = e.st;
                        pend = 1'b1;
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        exp_t held;
        in_valid = 1'b0; in_a = 64'd0; in_b = 64'd0; in_f = 5'd0;
        in_cin = 1'b0; in_cin_sel = 1'b0; in_len = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_status", {58'd0, out_status}, 64'd0);
        chk("rst_flags", {58'd0, flags}, 64'd0);
        chk("rst_alu_bus", {27'd0, alu_a, alu_b, alu_f, alu_cin}, 64'd0);
        rst_n = 1'b1;

        // 32-bit add: carry ripples from word 0 into word 1.
        send(64'h0000_0000_0000_FFFF, 64'h1, 5'd0, 1'b0, 1'b0, 2'd1);
        wait_valid();
        chk("add32_result", out_result, 64'h0000_0000_0001_0000);
        chk("add32_cf_zf", {62'd0, out_status[5:4]}, 64'd0);
        drain();

        // 64-bit all-ones + 1: carry into every upper word.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd0, 1'b0, 1'b0, 2'd3);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("add64_word_cin", {63'd0, alu_cin}, 64'd1);
        end
        wait_valid();
        chk("add64_result", out_result, 64'd0);
        chk("add64_cf_zf", {62'd0, out_status[5:4]}, 64'd3);
        drain();

        // Stored carry from the previous command feeds word 0.
        send(64'd0, 64'd0, 5'd0, 1'b0, 1'b1, 2'd0);
        wait_valid();
        chk("stored_cf_result", out_result, 64'h1);
        chk("stored_cf_zf", {63'd0, out_status[4]}, 64'd0);
        drain();

        // Backpressure: stall in DONE while a new command is offered.
        ready_mode = 2;
        send({$urandom, $urandom}, {$urandom, $urandom}, 5'd1, 1'b1, 1'b0, 2'd2);
        wait_valid();
        held = exp_q[0];
        in_a = 64'h1234_5678_9ABC_DEF0; in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("stall_result", out_result, held.res);
            chk("stall_status", {58'd0, out_status}, {58'd0, held.st});
            chk("stall_ready_valid", {62'd0, in_ready, out_valid}, 64'd1);
            chk("stall_flags", {58'd0, flags}, {58'd0, model_flags});
        end
        in_valid = 1'b0;
        ready_mode = 1;
        drain();

        // Random regression.
        ready_mode = 0;
        for (int i = 0; i < 1000; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        drain();

        // Make flags nonzero, then reset in the middle of a 64-bit command.
        ready_mode = 1;
        send(64'hFFFF, 64'h1, 5'd0, 1'b0, 1'b0, 2'd0);
        drain();
        send({$urandom, $urandom}, {$urandom, $urandom}, 5'd0, 1'b1, 1'b0, 2'd3);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_result", out_result, 64'd0);
        chk("midrst_out_status", {58'd0, out_status}, 64'd0);
        chk("midrst_flags", {58'd0, flags}, 64'd0);
        chk("midrst_alu_bus", {27'd0, alu_a, alu_b, alu_f, alu_cin}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("postrst_flags", {58'd0, flags}, 64'd0);
        send(64'h0000_0001_0002_0003, 64'h0000_0004_0005_0006, 5'd0, 1'b0, 1'b1, 2'd3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
